muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 107 ++++++++++
 tb/tb_muldiv_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Control sequencer for an iterative RV32M multiply/divide unit: stalls the
// pipeline, launches and steps the datapath, and flags the result cycle.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no op in flight; an M-op in EX stalls the pipe and launches
// BUSY  | datapath stepping; counter counts the remaining busy cycles
// DONE  | result captured into EX/MEM this cycle; stall released
module muldiv_sequencer #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ex_m_inst,
    input  logic [2:0] ex_funct3,
    input  logic [4:0] ex_rd,
    input  logic       div_special,
    input  logic       abort,
    output logic       stall,
    output logic       unit_start,
    output logic       unit_en,
    output logic [2:0] unit_op,
    output logic       result_valid,
    output logic [4:0] result_rd,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] MUL_LOAD = 7'(MUL_CYCLES - 1);
    localparam logic [6:0] DIV_LOAD = 7'(DIV_CYCLES - 1);

    state_t     state, state_nxt;
    logic [6:0] cnt, cnt_nxt;
    logic [2:0] op_nxt;
    logic [4:0] rd_nxt;
    logic       start_nxt;
    logic       stall_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 7'd0;
            unit_op    <= 3'd0;
            result_rd  <= 5'd0;
            unit_start <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            unit_op    <= op_nxt;
            result_rd  <= rd_nxt;
            unit_start <= start_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = unit_op;
        rd_nxt    = result_rd;
        start_nxt = 1'b0;
        stall_c   = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            cnt_nxt   = 7'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (ex_m_inst) begin
                        stall_c = 1'b1;
                        op_nxt  = ex_funct3;
                        rd_nxt  = ex_rd;
                        // Divide-by-zero and overflow have fixed results, so skip the datapath
                        if (ex_funct3[2] && div_special) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt = BUSY;
                            cnt_nxt   = ex_funct3[2] ? DIV_LOAD : MUL_LOAD;
                            start_nxt = 1'b1;
                        end
                    end
                end
                BUSY: begin
                    stall_c = 1'b1;
                    if (cnt == 7'd0) begin
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt - 7'd1;
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign stall        = stall_c;
    assign unit_en      = (state == BUSY);
    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE) && !abort;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: per-op cycle counts plus a result
// scoreboard of {op, rd} pushed at issue and popped on result_valid.
module tb_muldiv_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       ex_m_inst;
    logic [2:0] ex_funct3;
    logic [4:0] ex_rd;
    logic       div_special;
    logic       abort;
    logic       stall;
    logic       unit_start;
    logic       unit_en;
    logic [2:0] unit_op;
    logic       result_valid;
    logic [4:0] result_rd;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int st_cnt, en_cnt, start_cnt, rv_cnt, cyc, start_at, rv_at;
    logic [7:0] exp_q[$];

    muldiv_sequencer #(.MUL_CYCLES(2), .DIV_CYCLES(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_m_inst    (ex_m_inst),
        .ex_funct3    (ex_funct3),
        .ex_rd        (ex_rd),
        .div_special  (div_special),
        .abort        (abort),
        .stall        (stall),
        .unit_start   (unit_start),
        .unit_en      (unit_en),
        .unit_op      (unit_op),
        .result_valid (result_valid),
        .result_rd    (result_rd),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        st_cnt = 0; en_cnt = 0; start_cnt = 0; rv_cnt = 0;
        cyc = 0; start_at = -1; rv_at = -1;
    endtask

    task automatic monitor();
        logic [7:0] e;
        if (stall) st_cnt++;
        if (unit_en) en_cnt++;
        if (unit_start) begin
            start_cnt++;
            if (start_at < 0) start_at = cyc;
        end
        if (result_valid) begin
            rv_cnt++;
            if (rv_at < 0) rv_at = cyc;
            chk("stall_in_done", int'(stall), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("result_rd", int'(result_rd), int'(e[4:0]));
                chk("unit_op", int'(unit_op), int'(e[7:5]));
            end
        end
        cyc++;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled at the falling edge.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [4:0] rdv, input logic sp,
                          input logic hold, input int n);
        clear_counts();
        ex_m_inst = 1'b1; ex_funct3 = f3; ex_rd = rdv; div_special = sp;
        exp_q.push_back({f3, rdv});
        step();
        if (!hold) ex_m_inst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            step();
        end
        ex_m_inst = 1'b0; div_special = 1'b0;
        chk("op_timeout", int'(busy), 0);
        chk("rv_count", rv_cnt, 1);
        if (sp && f3[2]) begin
            chk("sp_stall", st_cnt, 1);
            chk("sp_en", en_cnt, 0);
            chk("sp_start", start_cnt, 0);
            chk("sp_rv_at", rv_at, 1);
        end else begin
            chk("stall_cycles", st_cnt, n + 1);
            chk("en_cycles", en_cnt, n);
            chk("start_count", start_cnt, 1);
            chk("start_at", start_at, 1);
            chk("rv_at", rv_at, n + 1);
        end
    endtask

    initial begin
        rst = 1'b1; ex_m_inst = 1'b0; ex_funct3 = 3'd0; ex_rd = 5'd0;
        div_special = 1'b0; abort = 1'b0;
        clear_counts();
        @(posedge clk); #1;
        step();
        rst = 1'b0;
        chk("rst_stall", int'(stall), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_start", int'(unit_start), 0);
        chk("rst_en", int'(unit_en), 0);
        chk("rst_rv", int'(result_valid), 0);
        chk("rst_op", int'(unit_op), 0);
        chk("rst_rd", int'(result_rd), 0);

        run_op(3'b000, 5'd5, 1'b0, 1'b0, 2);   // MUL
        run_op(3'b101, 5'd7, 1'b0, 1'b1, 32);  // DIVU, request held during BUSY
        run_op(3'b100, 5'd9, 1'b1, 1'b0, 0);   // DIV, divide by zero
        run_op(3'b011, 5'd1, 1'b1, 1'b0, 2);   // MULHU ignores div_special
        run_op(3'b000, 5'd3, 1'b0, 1'b0, 2);   // back-to-back MULs
        run_op(3'b000, 5'd4, 1'b0, 1'b0, 2);
        run_op(3'b111, 5'd31, 1'b0, 1'b0, 32); // REMU

        // Abort at BUSY cycle 10 of a DIV
        clear_counts();
        ex_m_inst = 1'b1; ex_funct3 = 3'b100; ex_rd = 5'd10;
        step();
        ex_m_inst = 1'b0;
        repeat (9) step();
        abort = 1'b1;
        @(negedge clk);
        chk("abort_stall", int'(stall), 0);
        chk("abort_rv", int'(result_valid), 0);
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle", int'(busy), 0);
        repeat (40) step();
        chk("abort_no_result", rv_cnt, 0);
        chk("abort_stall_total", st_cnt, 10);

        // Abort during the DONE cycle of a special divide
        clear_counts();
        ex_m_inst = 1'b1; ex_funct3 = 3'b110; ex_rd = 5'd2; div_special = 1'b1;
        step();
        ex_m_inst = 1'b0; div_special = 1'b0;
        chk("sp_in_done", int'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        chk("abort_done_rv", int'(result_valid), 0);
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_done_idle", int'(busy), 0);

        // Abort alongside a request in IDLE: request dropped
        ex_m_inst = 1'b1; ex_funct3 = 3'b000; ex_rd = 5'd6; abort = 1'b1;
        @(negedge clk);
        chk("abort_idle_stall", int'(stall), 0);
        @(posedge clk); #1;
        ex_m_inst = 1'b0; abort = 1'b0;
        chk("abort_idle_busy", int'(busy), 0);
        chk("abort_idle_start", int'(unit_start), 0);

        // Reset at BUSY cycle 5 of a DIV, then a clean MUL
        clear_counts();
        ex_m_inst = 1'b1; ex_funct3 = 3'b110; ex_rd = 5'd12;
        step();
        ex_m_inst = 1'b0;
        repeat (4) step();
        chk("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_stall", int'(stall), 0);
        chk("mid_rst_start", int'(unit_start), 0);
        chk("mid_rst_en", int'(unit_en), 0);
        chk("mid_rst_rv", int'(result_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_op", int'(unit_op), 0);
        chk("mid_rst_rd", int'(result_rd), 0);
        chk("mid_rst_no_result", rv_cnt, 0);
        run_op(3'b000, 5'd5, 1'b0, 1'b0, 2);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
